// File: rtl/collatz_pkg.sv
// Shared widths, state encoding and result record for the Collatz statistics block.
package collatz_pkg;

  localparam int SEED_W = 16;
  localparam int K_W    = 20;
  localparam int STEP_W = 12;

  // Smallest odd iterate whose 3k+1 no longer fits in K_W bits.
  localparam logic [K_W-1:0] OVF_LIMIT = K_W'((2**K_W - 1) / 3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SEED_W-1:0] seed;
    logic [STEP_W-1:0] steps;
    logic [K_W-1:0]    peak;
    logic              sat;
    logic              ovf;
  } res_t;

endpackage

// File: rtl/collatz_acc.sv
// Step/peak/flag accumulator for one Collatz sequence; clear has priority over update.
module collatz_acc
  import collatz_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              upd,
  input  logic [SEED_W-1:0] seed,
  input  logic [K_W-1:0]    k,
  output logic [STEP_W-1:0] steps,
  output logic [K_W-1:0]    peak,
  output logic              sat,
  output logic              ovf
);

  logic [STEP_W-1:0] steps_q, steps_d;
  logic [K_W-1:0]    peak_q, peak_d;
  logic              sat_q, sat_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    steps_d = steps_q;
    peak_d  = peak_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    if (clr) begin
      steps_d = '0;
      peak_d  = K_W'(seed);
      sat_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (upd) begin
      // The counter holds at all-ones; a strobe arriving there marks saturation.
      if (&steps_q) begin
        sat_d = 1'b1;
      end else begin
        steps_d = steps_q + STEP_W'(1);
      end
      if (k > peak_q) begin
        peak_d = k;
      end
      if (k[0] && (k >= OVF_LIMIT)) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      steps_q <= '0;
      peak_q  <= '0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      steps_q <= steps_d;
      peak_q  <= peak_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign steps = steps_q;
  assign peak  = peak_q;
  assign sat   = sat_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/collatz_stats.sv
// Tracks a running Collatz sequence and presents one result record per sequence
// over a valid/ready handshake; a start accepted with the handshake restarts with no bubble.
module collatz_stats
  import collatz_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st,
  input  logic [SEED_W-1:0] co,
  input  logic [K_W-1:0]    k,
  input  logic              k_valid,
  input  logic              seq_done,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SEED_W-1:0] res_seed,
  output logic [STEP_W-1:0] res_steps,
  output logic [K_W-1:0]    res_peak,
  output logic              res_sat,
  output logic              res_ovf
);

  state_e            state_q, state_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic              acc_clr;
  logic              acc_upd;
  res_t              res;

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    acc_clr = 1'b0;
    acc_upd = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (st) begin
          state_d = ST_TRACK;
          seed_d  = co;
          acc_clr = 1'b1;
        end
      end
      ST_TRACK: begin
        acc_upd = k_valid;
        if (seq_done) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Starts are only honoured together with the handshake so a pending record is never lost.
        if (res_ready) begin
          if (st) begin
            state_d = ST_TRACK;
            seed_d  = co;
            acc_clr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
    end
  end

  collatz_acc u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .upd   (acc_upd),
    .seed  (co),
    .k     (k),
    .steps (res.steps),
    .peak  (res.peak),
    .sat   (res.sat),
    .ovf   (res.ovf)
  );

  assign res.seed  = seed_q;
  assign busy      = (state_q == ST_TRACK);
  assign res_valid = (state_q == ST_HOLD);
  assign res_seed  = res.seed;
  assign res_steps = res.steps;
  assign res_peak  = res.peak;
  assign res_sat   = res.sat;
  assign res_ovf   = res.ovf;

endmodule

// File: tb/tb_collatz_stats.sv
// Randomized and directed check of collatz_stats against a sequence-level reference model.
module tb_collatz_stats;
  import collatz_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, st, k_valid, seq_done, res_ready;
  logic [SEED_W-1:0] co;
  logic [K_W-1:0]    k;
  logic              busy, res_valid, res_sat, res_ovf;
  logic [SEED_W-1:0] res_seed;
  logic [STEP_W-1:0] res_steps;
  logic [K_W-1:0]    res_peak;

  int n_vec = 0;
  int n_err = 0;
  int kq[$];

  collatz_stats dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st        (st),
    .co        (co),
    .k         (k),
    .k_valid   (k_valid),
    .seq_done  (seq_done),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_seed  (res_seed),
    .res_steps (res_steps),
    .res_peak  (res_peak),
    .res_sat   (res_sat),
    .res_ovf   (res_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Iterates the true Collatz map; the core only ever shows the low K_W bits.
  task automatic gen_collatz(input int seed);
    longint x;
    x = seed;
    kq.delete();
    while (x > 1) begin
      x = (x % 2 == 1) ? 3 * x + 1 : x / 2;
      kq.push_back(int'(x % (64'd1 << K_W)));
    end
  endtask

  task automatic model(input int seed, output res_t r);
    int n;
    int smax;
    n    = kq.size();
    smax = (1 << STEP_W) - 1;
    r.seed  = SEED_W'(seed);
    r.steps = (n > smax) ? STEP_W'(smax) : STEP_W'(n);
    r.sat   = (n > smax);
    r.peak  = K_W'(seed);
    r.ovf   = 1'b0;
    foreach (kq[i]) begin
      if (kq[i] > int'(r.peak)) r.peak = K_W'(kq[i]);
      if ((kq[i] % 2 == 1) && (3 * longint'(kq[i]) + 1 >= (64'd1 << K_W))) r.ovf = 1'b1;
    end
  endtask

  task automatic start(input int seed);
    st = 1'b1;
    co = SEED_W'(seed);
    tick();
    st = 1'b0;
    co = SEED_W'($urandom);
  endtask

  task automatic feed(input bit coin, input int max_gap, input bit noise);
    int n;
    int gap;
    n = kq.size();
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
        k = K_W'($urandom);
        if (noise && ($urandom_range(7, 0) == 0)) st = 1'b1;
        tick();
        st = 1'b0;
      end
      k_valid  = 1'b1;
      k        = K_W'(kq[i]);
      seq_done = coin && (i == n - 1);
      tick();
      k_valid  = 1'b0;
      seq_done = 1'b0;
    end
    if (!(coin && n > 0)) begin
      seq_done = 1'b1;
      tick();
      seq_done = 1'b0;
    end
  endtask

  task automatic check_rec(input string t, input int seed);
    res_t e;
    model(seed, e);
    chk({t, ".valid"}, 32'(res_valid), 32'd1);
    chk({t, ".busy"},  32'(busy),      32'd0);
    chk({t, ".seed"},  32'(res_seed),  32'(e.seed));
    chk({t, ".steps"}, 32'(res_steps), 32'(e.steps));
    chk({t, ".peak"},  32'(res_peak),  32'(e.peak));
    chk({t, ".sat"},   32'(res_sat),   32'(e.sat));
    chk({t, ".ovf"},   32'(res_ovf),   32'(e.ovf));
  endtask

  task automatic accept(input string t, input int wait_max, input int seed);
    res_t e;
    int w;
    model(seed, e);
    w = $urandom_range(wait_max, 0);
    repeat (w) begin
      tick();
      chk({t, ".hold_valid"}, 32'(res_valid), 32'd1);
      chk({t, ".hold_steps"}, 32'(res_steps), 32'(e.steps));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({t, ".acc_valid"}, 32'(res_valid), 32'd0);
    chk({t, ".acc_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    int seed;
    int mode;
    res_t e;
    st = 1'b0; co = '0; k = '0; k_valid = 1'b0; seq_done = 1'b0; res_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst.busy",  32'(busy),      32'd0);
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.seed",  32'(res_seed),  32'd0);
    chk("rst.steps", 32'(res_steps), 32'd0);
    chk("rst.peak",  32'(res_peak),  32'd0);
    chk("rst.flags", 32'({res_sat, res_ovf}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Strobes and done in IDLE must not disturb anything.
    k_valid = 1'b1; k = 20'hFFFFF; seq_done = 1'b1;
    tick(); tick();
    k_valid = 1'b0; seq_done = 1'b0;
    chk("idle.busy",  32'(busy),      32'd0);
    chk("idle.valid", 32'(res_valid), 32'd0);

    gen_collatz(6);
    start(6);
    chk("s6.busy_on", 32'(busy), 32'd1);
    feed(1'b0, 2, 1'b0);
    check_rec("s6", 6);
    chk("s6.const_steps", 32'(res_steps), 32'd8);
    chk("s6.const_peak",  32'(res_peak),  32'd16);
    accept("s6", 2, 6);

    gen_collatz(27);
    start(27);
    feed(1'b0, 0, 1'b0);
    check_rec("s27", 27);
    chk("s27.const_steps", 32'(res_steps), 32'd111);
    chk("s27.const_peak",  32'(res_peak),  32'd9232);
    res_ready = 1'b1; st = 1'b1; co = 16'd6;
    tick();
    st = 1'b0; res_ready = 1'b0;
    chk("b2b.valid", 32'(res_valid), 32'd0);
    chk("b2b.busy",  32'(busy),      32'd1);
    gen_collatz(6);
    feed(1'b1, 1, 1'b0);
    check_rec("b2b", 6);
    accept("b2b", 0, 6);

    // Odd iterates just below the limit and even ones above it leave ovf clear.
    kq = '{349523, 349524, 349526};
    start(7); feed(1'b0, 1, 1'b0); check_rec("ovf0", 7); accept("ovf0", 1, 7);
    kq = '{349525, 1048575};
    start(7); feed(1'b0, 1, 1'b0); check_rec("ovf1", 7); accept("ovf1", 1, 7);

    kq.delete();
    repeat (4095) kq.push_back(1);
    start(3); feed(1'b0, 0, 1'b0); check_rec("s4095", 3); accept("s4095", 0, 3);
    repeat (5) kq.push_back(1);
    start(3); feed(1'b0, 0, 1'b0); check_rec("sat", 3); accept("sat", 0, 3);

    gen_collatz(10);
    start(10);
    feed(1'b0, 1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin st = 1'b1; co = 16'd9; end
      if (c == 12) begin k_valid = 1'b1; k = 20'd99999; seq_done = 1'b1; end
      tick();
      st = 1'b0; k_valid = 1'b0; seq_done = 1'b0;
      check_rec("bp", 10);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp.valid", 32'(res_valid), 32'd0);
    chk("bp.busy",  32'(busy),      32'd0);
    tick();
    chk("bp.idle", 32'(busy), 32'd0);

    kq.delete();
    start(1);
    tick();
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    check_rec("s1", 1);
    accept("s1", 1, 1);

    // seq_done alongside an accepted start is ignored.
    st = 1'b1; seq_done = 1'b1; co = 16'd5;
    tick();
    st = 1'b0; seq_done = 1'b0;
    chk("stdone.busy", 32'(busy), 32'd1);
    gen_collatz(5);
    feed(1'b1, 1, 1'b0);
    check_rec("stdone", 5);
    accept("stdone", 1, 5);

    gen_collatz(6);
    start(6);
    for (int i = 0; i < 3; i++) begin
      k_valid = 1'b1; k = K_W'(kq[i]);
      tick();
    end
    k_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst.busy",  32'(busy),      32'd0);
    chk("mrst.valid", 32'(res_valid), 32'd0);
    chk("mrst.steps", 32'(res_steps), 32'd0);
    seq_done = 1'b1;
    tick();
    seq_done = 1'b0;
    tick();
    chk("mrst.norec", 32'(res_valid), 32'd0);

    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(2, 0);
      if (mode == 0) begin
        seed = $urandom_range(65535, 0);
        gen_collatz(seed);
      end else if (mode == 1) begin
        seed = $urandom_range(65535, 0);
        kq.delete();
        repeat ($urandom_range(30, 0)) begin
          if ($urandom_range(1, 0) == 1) kq.push_back(int'(OVF_LIMIT) + $urandom_range(4, 0) - 2);
          else kq.push_back(int'($urandom_range(1048575, 0)));
        end
      end else begin
        seed = $urandom_range(50, 0);
        gen_collatz(seed);
      end
      start(seed);
      feed(1'($urandom_range(1, 0)), 2, 1'b1);
      check_rec($sformatf("rnd%0d", it), seed);
      accept($sformatf("rnd%0d", it), 3, seed);
    end

    model(0, e);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
